// File: rtl/axi_master.sv
// AXI4-Lite master: one single-beat command in flight; rsp_valid 3 cycles after accept with a zero-wait slave.
// cmd_ready is high only in IDLE; the response is held until rsp_ready, and AXI valids are held until their ready.
`timescale 1ns/1ps
module axi_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  timeout_err,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state;
  logic          aw_done, w_done;
  logic [CW-1:0] wait_cnt;

  logic aw_hs, w_hs, aw_fin, w_fin;
  logic phase_active, phase_done;

  assign cmd_ready = (state == IDLE);
  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign aw_fin    = aw_done | aw_hs;
  assign w_fin     = w_done | w_hs;

  // A phase is any state waiting on the slave; done means its handshake completes this cycle.
  always_comb begin
    phase_active = 1'b0;
    phase_done   = 1'b0;
    case (state)
      WR_AW_W: begin phase_active = 1'b1; phase_done = aw_fin & w_fin;    end
      WR_B:    begin phase_active = 1'b1; phase_done = bvalid & bready;   end
      RD_AR:   begin phase_active = 1'b1; phase_done = arvalid & arready; end
      RD_R:    begin phase_active = 1'b1; phase_done = rvalid & rready;   end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      awaddr      <= '0;
      awvalid     <= 1'b0;
      wdata       <= '0;
      wstrb       <= '0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
    end else begin
      // Counter restarts whenever a phase is entered; it saturates so the pulse fires once per phase.
      timeout_err <= 1'b0;
      if (!phase_active || phase_done) begin
        wait_cnt <= '0;
      end else if (TIMEOUT_CYCLES != 0 && wait_cnt != TO_MAX) begin
        wait_cnt <= wait_cnt + CW'(1);
        if (wait_cnt == TO_LAST) timeout_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_write) begin
              awaddr  <= cmd_addr;
              wdata   <= cmd_wdata;
              wstrb   <= cmd_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= WR_AW_W;
            end else begin
              araddr  <= cmd_addr;
              arvalid <= 1'b1;
              state   <= RD_AR;
            end
          end
        end
        WR_AW_W: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready <= 1'b1;
            state  <= WR_B;
          end
        end
        WR_B: begin
          if (bvalid) begin
            bready    <= 1'b0;
            rsp_resp  <= bresp;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RD_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_R;
          end
        end
        RD_R: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rsp_rdata <= rdata;
            rsp_resp  <= rresp;
            rsp_write <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master.sv
// Randomized scoreboard bench for axi_master against a word-memory reference and a delay-programmable AXI4-Lite slave.
`timescale 1ns/1ps
module tb_axi_master;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_write, timeout_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  axi_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
    int          tos;
    int          hold;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, passed = 0;
  int          cyc = 0, acc_cyc = 0, to_cnt = 0, to_base = 0;
  int          cur_da = 0, cur_dw = 0, cur_db = 0, cur_dar = 0, cur_dr = 0;
  logic [31:0] mmem [0:255] = '{default: '0};
  logic [31:0] smem [0:255] = '{default: '0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && timeout_err) to_cnt++;

  // Slave: each channel's ready/valid is given after the programmed number of wait cycles; resp code = addr[9:8].
  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic        aw_got = 0, w_got = 0, wr_done = 0;
  logic [31:0] aw_l, aw_prev, rd_l;
  logic [35:0] w_l, w_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      aw_got = 0; w_got = 0; wr_done = 0;
    end else begin
      if (awready) begin
        awready = 0;
        chk("awvalid_drop", awvalid, 0);
      end else if (awvalid) begin
        if (aw_wait > 0) chk("awaddr_stable", awaddr, aw_prev);
        aw_prev = awaddr;
        if (aw_wait == cur_da) begin awready = 1; aw_l = awaddr; aw_got = 1; aw_wait = 0; end
        else aw_wait++;
      end
      if (wready) begin
        wready = 0;
        chk("wvalid_drop", wvalid, 0);
      end else if (wvalid) begin
        if (w_wait > 0) chk("wdata_stable", {wdata, wstrb}, w_prev);
        w_prev = {wdata, wstrb};
        if (w_wait == cur_dw) begin wready = 1; w_l = {wdata, wstrb}; w_got = 1; w_wait = 0; end
        else w_wait++;
      end
      if (aw_got && w_got) begin
        for (int b = 0; b < 4; b++)
          if (w_l[b]) smem[aw_l[9:2]][8*b +: 8] = w_l[4 + 8*b +: 8];
        aw_got = 0; w_got = 0; wr_done = 1;
      end
      if (bvalid) begin
        bvalid = 0; wr_done = 0;
        chk("bready_drop", bready, 0);
      end else if (bready) begin
        if (b_wait == 0) chk("bready_after_aw_w", wr_done, 1);
        if (b_wait == cur_db) begin bvalid = 1; bresp = aw_l[9:8]; b_wait = 0; end
        else b_wait++;
      end
      if (arready) begin
        arready = 0;
        chk("arvalid_drop", arvalid, 0);
      end else if (arvalid) begin
        if (ar_wait == cur_dar) begin arready = 1; rd_l = araddr; ar_wait = 0; end
        else ar_wait++;
      end
      rdata = $urandom;
      if (rvalid) begin
        rvalid = 0;
        chk("rready_drop", rready, 0);
      end else if (rready) begin
        if (r_wait == cur_dr) begin
          rvalid = 1; rdata = smem[rd_l[9:2]]; rresp = rd_l[9:8]; r_wait = 0;
        end else r_wait++;
      end
    end
  end

  // Monitor: pops one expectation per response and checks fields, latency, timeout pulses and hold stability.
  initial begin
    exp_t e;
    logic [34:0] snap;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL rsp_unexpected: rsp_valid=1 with no outstanding command");
          rsp_ready = 1; @(negedge clk); rsp_ready = 0;
        end else begin
          e = q.pop_front();
          chk("rsp_write", rsp_write, e.wr);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", rsp_resp, e.resp);
          chk("latency", cyc - acc_cyc, e.lat);
          chk("timeout_pulses", to_cnt - to_base, e.tos);
          chk("cmd_ready_busy", cmd_ready, 0);
          snap = {rsp_write, rsp_rdata, rsp_resp};
          repeat (e.hold) begin
            @(negedge clk);
            chk("rsp_stable", {rsp_valid, rsp_write, rsp_rdata, rsp_resp}, {1'b1, snap});
            chk("cmd_ready_hold", cmd_ready, 0);
          end
          rsp_ready = 1;
          @(negedge clk);
          rsp_ready = 0;
          chk("rsp_valid_drop", rsp_valid, 0);
          chk("cmd_ready_after_rsp", cmd_ready, 1);
        end
      end
    end
  end

  // Presents a command, records the model's expectation at the accepting edge, then withdraws it.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int d0, input int d1, input int d2, input int hold);
    exp_t e;
    int   n, wmax;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        checks++;
        $display("FAIL cmd_accept: cmd_ready still 0 after %0d cycles, required 1", n);
        cmd_valid = 0;
        return;
      end
    end
    e.wr = wr; e.resp = addr[9:8]; e.hold = hold;
    if (wr) begin
      cur_da = d0; cur_dw = d1; cur_db = d2;
      wmax = (d0 > d1) ? d0 : d1;
      e.rdata = '0;
      e.lat = 3 + wmax + d2;
      e.tos = int'(wmax >= TO) + int'(d2 >= TO);
      for (int b = 0; b < 4; b++)
        if (strb[b]) mmem[addr[9:2]][8*b +: 8] = data[8*b +: 8];
    end else begin
      cur_dar = d0; cur_dr = d1;
      e.rdata = mmem[addr[9:2]];
      e.lat = 3 + d0 + d1;
      e.tos = int'(d0 >= TO) + int'(d1 >= TO);
    end
    acc_cyc = cyc;
    to_base = to_cnt;
    q.push_back(e);
    @(negedge clk);
    cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
  endtask

  initial begin
    int n;
    #1;
    chk("rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, timeout_err, rsp_write, rsp_resp, wstrb}, 0);
    chk("rst_addr", {awaddr, araddr}, 0);
    chk("rst_data", {wdata, rsp_rdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);

    issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    issue(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0);
    issue(1, 32'h14, 32'hCAFEF00D, 4'hF, 3, 0, 0, 0);
    issue(1, 32'h20, 32'h11223344, 4'hF, 0, 0, 0, 0);
    issue(1, 32'h20, 32'h000000AA, 4'h1, 0, 0, 0, 0);
    issue(0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 5);
    issue(1, 32'h24, 32'h5A5A5A5A, 4'hF, 0, 1, 0, 0);
    issue(0, 32'h10, 32'h0, 4'h0, 10, 0, 0, 0);

    // Reset while the master waits in WR_B; the slave already took the write data.
    issue(1, 32'h40, 32'h01020304, 4'hF, 0, 0, 6, 0);
    n = 0;
    while (!bready && n < 50) begin @(negedge clk); n++; end
    chk("reach_wr_b", bready, 1);
    rst_n = 0;
    #1;
    chk("midrst_ctrl", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, timeout_err, rsp_write, rsp_resp, wstrb}, 0);
    chk("midrst_addr", {awaddr, araddr}, 0);
    chk("midrst_data", {wdata, rsp_rdata}, 0);
    chk("midrst_idle", cmd_ready, 1);
    if (q.size() > 0) void'(q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    issue(1, 32'h44, 32'h0BADF00D, 4'hF, 0, 0, 0, 0);
    issue(0, 32'h44, 32'h0, 4'h0, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 255)) << 2;
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 3));
    end

    n = 0;
    while (q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
    end
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axi_master.md
Name: axi_master

Overview:
AXI4-Lite master that turns single-beat commands from a simple valid/ready command port into AXI4-Lite write or read transactions. It returns the response (read data plus RESP code) on a valid/ready response port. It sits between the team's register-access and control logic and axi_slave-style AXI4-Lite targets. There is one outstanding transaction at a time; AW and W are issued concurrently and complete independently.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr, awaddr and araddr
DATA_WIDTH, 32, data width; fixed at 32 (wstrb is 4 bits)
TIMEOUT_CYCLES, 256, number of wait cycles on any AXI phase before timeout_err pulses; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  4  byte enables
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_resp  out  2  captured BRESP or RRESP
timeout_err  out  1  one-cycle pulse when a phase exceeds TIMEOUT_CYCLES
awaddr, awvalid  out  ADDR_WIDTH, 1  AW channel
awready  in  1
wdata, wstrb, wvalid  out  DATA_WIDTH, 4, 1  W channel
wready  in  1
bresp, bvalid  in  2, 1  B channel
bready  out  1
araddr, arvalid  out  ADDR_WIDTH, 1  AR channel
arready  in  1
rdata, rresp, rvalid  in  DATA_WIDTH, 2, 1  R channel
rready  out  1

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All outputs are registered except cmd_ready.
- Reset values: state IDLE, all valid/ready outputs 0, addr/data/strb/rdata/resp outputs 0, timeout_err 0.
- Reset mid-transaction: all outputs are forced to their reset values immediately and the transaction is abandoned.
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- IDLE:
  - cmd_ready = 1 combinationally while in IDLE, 0 in every other state.
  - On accept: latch addr, wdata and wstrb onto awaddr/araddr, wdata and wstrb.
  - Write: go to WR_AW_W; awvalid and wvalid are both 1 on the next cycle.
  - Read: go to RD_AR; arvalid is 1 on the next cycle.
- WR_AW_W:
  - Track aw_done and w_done separately.
  - awvalid drops the cycle after awvalid and awready are both high; wvalid likewise after wvalid and wready.
  - A valid is never dropped before its handshake. The master never waits for ready before asserting valid.
  - awaddr, wdata and wstrb stay stable while their valid is high.
  - When both handshakes are done (same cycle or different cycles), go to WR_B with bready = 1 on the next cycle.
- WR_B:
  - On bvalid and bready both high: capture bresp into rsp_resp, set rsp_write = 1 and rsp_rdata = 0, drop bready, go to RESP.
  - bvalid arriving before bready is asserted is held by the slave and is accepted once bready is 1.
- RD_AR: arvalid is held until arready; on the handshake, drop arvalid, raise rready, go to RD_R.
- RD_R: on rvalid and rready both high, capture rdata and rresp, set rsp_write = 0, drop rready, go to RESP.
- RESP: rsp_valid = 1 and the rsp_* fields are held stable until rsp_ready; on that handshake rsp_valid = 0 and the state returns to IDLE. The next command can be accepted one cycle later.
- Minimum latency: command accept in cycle 0. With a zero-wait slave: AW/W handshake in cycle 1, B handshake in cycle 2, rsp_valid in cycle 3. Reads follow the same count.
- Error responses: SLVERR and DECERR are passed through unchanged on rsp_resp. No retry.
- Timeout:
  - A wait counter clears on entry to WR_AW_W, WR_B, RD_AR and RD_R, and increments each cycle spent in that state.
  - When it reaches TIMEOUT_CYCLES, timeout_err pulses for exactly one cycle and the counter saturates (no further pulses in that state).
  - Valid signals remain asserted after a timeout; the transaction still completes normally.
- Commands presented while not in IDLE are not accepted; cmd_* inputs are ignored.

Test Plan:
1. Write 0xDEADBEEF to 0x10, wstrb 0xF, zero-wait slave -> awvalid/wvalid high in cycle 1, rsp_valid in cycle 3 with rsp_write = 1, rsp_resp = 00; a following read of 0x10 returns rsp_rdata = 0xDEADBEEF.
2. Slave asserts awready 3 cycles after wready -> wvalid drops after the W handshake, awvalid stays high with awaddr stable, bready rises only after the AW handshake, and the response completes correctly.
3. Partial write of 0x000000AA to 0x20 with wstrb 0x1 after 0x11223344 -> read of 0x20 returns 0x112233AA.
4. rsp_ready held low for 5 cycles -> rsp_valid and the rsp_* fields stay stable, cmd_ready stays 0, and a new command is accepted the cycle after the rsp handshake.
5. TIMEOUT_CYCLES = 4 and arready withheld for 10 cycles -> timeout_err pulses once at wait cycle 4, arvalid stays high, and the read completes when arready arrives.
6. rst_n asserted while in WR_B -> all outputs return to 0 asynchronously and the state returns to IDLE; after release, a new write completes with RESP 00.
